// File: rtl/reaction_timer_multi.sv
// Multi-round reaction timer core.
// Lights the LED after a pseudo-random delay and measures the time to the stop press in ticks.
// Detects false starts, collects ROUNDS valid scores and reports their average.
// Produces four 4-bit display codes for the 7-segment muxer.
module reaction_timer_multi #(
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned TICK_HZ   = 1000,
    parameter int unsigned MIN_DELAY = 1000,
    parameter int unsigned RAND_BITS = 12,
    parameter int unsigned ROUNDS    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic        show_avg,
    output logic        led,
    output logic [15:0] digits,
    output logic [3:0]  round_idx,
    output logic        foul,
    output logic        session_done
);

    localparam int unsigned Div    = CLK_HZ / TICK_HZ;
    localparam int unsigned PW     = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned RLog   = (ROUNDS > 1) ? $clog2(ROUNDS) : 0;
    localparam int unsigned SW     = 14 + RLog;
    localparam int unsigned DMax   = MIN_DELAY + (2 ** RAND_BITS) - 1;
    localparam int unsigned DW     = (DMax > 1) ? $clog2(DMax + 1) : 1;

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWait   = 3'd1;
    localparam logic [2:0] StTiming = 3'd2;
    localparam logic [2:0] StResult = 3'd3;
    localparam logic [2:0] StFoul   = 3'd4;
    localparam logic [2:0] StAvg    = 3'd5;

    localparam logic [15:0] DispHi   = 16'hCABC;
    localparam logic [15:0] DispDash = 16'hCCCC;
    localparam logic [15:0] DispFoul = 16'hDCCC;
    localparam logic [15:0] DispOff  = 16'hFFFF;
    localparam logic [13:0] ScoreMax = 14'd9999;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [13:0]   score_q, score_d;
    logic [15:0]   bcd_q, bcd_d;
    logic [15:0]   last_bcd_q, last_bcd_d;
    logic [15:0]   avg_bcd_q, avg_bcd_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [4:0]    round_q, round_d;
    logic          done_q, done_d;
    logic          show_q, show_d;
    logic [29:0]   dd_q, dd_d;
    logic [3:0]    dd_cnt_q, dd_cnt_d;

    logic          tick;
    logic          lfsr_fb;
    logic [DW-1:0] delay_load;
    logic [13:0]   score_fin;
    logic [15:0]   bcd_inc_val;
    logic [15:0]   bcd_fin;
    logic [29:0]   dd_next;
    logic [13:0]   avg_bin;
    logic          load_round;
    logic          clear_sess;

    // Increment a 4-digit packed BCD value.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // One shift-add-3 step over {bcd[15:0], bin[13:0]}.
    function automatic logic [29:0] dd_step(input logic [29:0] v);
        logic [15:0] b;
        b = v[29:14];
        for (int i = 0; i < 4; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                b[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return {b[14:0], v[13:0], 1'b0};
    endfunction

    assign tick        = (presc_q == PW'(Div - 1));
    assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    assign delay_load  = DW'(MIN_DELAY) + DW'(lfsr_q[RAND_BITS-1:0]);
    // A tick landing in the same cycle as the stop still counts.
    assign score_fin   = tick ? (score_q + 14'd1) : score_q;
    assign bcd_inc_val = bcd_inc(bcd_q);
    assign bcd_fin     = tick ? bcd_inc_val : bcd_q;
    assign dd_next     = dd_step(dd_q);
    assign avg_bin     = sum_q[RLog +: 14];

    // Next-state logic for the round/session sequencer and its datapath.
    always_comb begin
        state_d    = state_q;
        lfsr_d     = {lfsr_q[14:0], lfsr_fb};
        delay_d    = delay_q;
        score_d    = score_q;
        bcd_d      = bcd_q;
        last_bcd_d = last_bcd_q;
        avg_bcd_d  = avg_bcd_q;
        sum_d      = sum_q;
        round_d    = round_q;
        done_d     = done_q;
        show_d     = show_avg;
        dd_d       = dd_q;
        dd_cnt_d   = dd_cnt_q;
        load_round = 1'b0;
        clear_sess = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    clear_sess = 1'b1;
                    load_round = 1'b1;
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (stop) begin
                    state_d = StFoul;
                end else if (delay_q == '0) begin
                    state_d = StTiming;
                end else if (tick) begin
                    delay_d = delay_q - DW'(1);
                    if (delay_q == DW'(1)) begin
                        state_d = StTiming;
                    end
                end
                if (state_d == StTiming) begin
                    score_d = '0;
                    bcd_d   = '0;
                end
            end
            StTiming: begin
                // Reaching 9999 without a press ends the round as if stop were pressed.
                if (stop || (tick && (score_q == ScoreMax - 14'd1))) begin
                    last_bcd_d = bcd_fin;
                    sum_d      = sum_q + SW'(score_fin);
                    round_d    = round_q + 5'd1;
                    state_d    = StResult;
                end else if (tick) begin
                    score_d = score_q + 14'd1;
                    bcd_d   = bcd_inc_val;
                end
            end
            StResult: begin
                if ((round_q == 5'(ROUNDS)) && !done_q) begin
                    dd_d     = {16'd0, avg_bin};
                    dd_cnt_d = 4'd0;
                    state_d  = StAvg;
                end else if (start) begin
                    clear_sess = done_q;
                    load_round = 1'b1;
                    state_d    = StWait;
                end
            end
            StFoul: begin
                if (start) begin
                    load_round = 1'b1;
                    state_d    = StWait;
                end
            end
            StAvg: begin
                dd_d     = dd_next;
                dd_cnt_d = dd_cnt_q + 4'd1;
                if (dd_cnt_q == 4'd13) begin
                    avg_bcd_d = dd_next[29:14];
                    done_d    = 1'b1;
                    state_d   = StResult;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clear_sess) begin
            sum_d   = '0;
            round_d = '0;
            done_d  = 1'b0;
        end
        if (load_round) begin
            delay_d = delay_load;
            score_d = '0;
            bcd_d   = '0;
        end

        // Prescaler restarts on every state entry so tick phase is relative to entry.
        if ((state_d != state_q) || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            presc_q    <= '0;
            lfsr_q     <= 16'hACE1;
            delay_q    <= '0;
            score_q    <= '0;
            bcd_q      <= '0;
            last_bcd_q <= '0;
            avg_bcd_q  <= '0;
            sum_q      <= '0;
            round_q    <= '0;
            done_q     <= 1'b0;
            show_q     <= 1'b0;
            dd_q       <= '0;
            dd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            lfsr_q     <= lfsr_d;
            delay_q    <= delay_d;
            score_q    <= score_d;
            bcd_q      <= bcd_d;
            last_bcd_q <= last_bcd_d;
            avg_bcd_q  <= avg_bcd_d;
            sum_q      <= sum_d;
            round_q    <= round_d;
            done_q     <= done_d;
            show_q     <= show_d;
            dd_q       <= dd_d;
            dd_cnt_q   <= dd_cnt_d;
        end
    end

    // Output decode from the registered state.
    always_comb begin
        digits = DispOff;
        case (state_q)
            StIdle:   digits = DispHi;
            StWait:   digits = DispDash;
            StTiming: digits = bcd_q;
            StResult: digits = (done_q && show_q) ? avg_bcd_q : last_bcd_q;
            StFoul:   digits = DispFoul;
            StAvg:    digits = DispDash;
            default:  digits = DispOff;
        endcase
    end

    assign led          = (state_q == StTiming);
    assign foul         = (state_q == StFoul);
    assign session_done = done_q;
    // Port is 4 bits wide; a 16-round session saturates the display count at 15.
    assign round_idx    = (round_q > 5'd15) ? 4'hF : round_q[3:0];

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Scoreboard bench for reaction_timer_multi: stimulus queues expected round results,
// a forked monitor compares them when the DUT shows a round, foul or session event.
module tb_reaction_timer_multi;

    localparam int CLK_HZ    = 4;
    localparam int TICK_HZ   = 1;
    localparam int MIN_DELAY = 2;
    localparam int RAND_BITS = 2;
    localparam int ROUNDS    = 4;
    localparam int DIV       = CLK_HZ / TICK_HZ;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        stop;
    logic        show_avg;
    logic        led;
    logic [15:0] digits;
    logic [3:0]  round_idx;
    logic        foul;
    logic        session_done;

    typedef struct {
        string name;
        int    dig;
        int    rnd;
        int    fl;
        int    sd;
        int    ld;
    } exp_t;

    exp_t sbq[$];
    int   scores[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    reaction_timer_multi #(
        .CLK_HZ   (CLK_HZ),
        .TICK_HZ  (TICK_HZ),
        .MIN_DELAY(MIN_DELAY),
        .RAND_BITS(RAND_BITS),
        .ROUNDS   (ROUNDS)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .show_avg    (show_avg),
        .led         (led),
        .digits      (digits),
        .round_idx   (round_idx),
        .foul        (foul),
        .session_done(session_done)
    );

    always #5 clock = ~clock;

    function automatic int to_bcd(int v);
        return (((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) |
               (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    function automatic int avg_of_scores();
        int s;
        s = 0;
        foreach (scores[i]) s += scores[i];
        return s / ROUNDS;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_range(string name, int v, int lo, int hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, v, lo, hi);
        end
    endtask

    task automatic push_exp(string nm, int dig, int rnd, int fl, int sd, int ld);
        exp_t e;
        e.name = nm;
        e.dig  = dig;
        e.rnd  = rnd;
        e.fl   = fl;
        e.sd   = sd;
        e.ld   = ld;
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic pulse_both();
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
    endtask

    // Counts cycles from the start edge to the LED rise: must be delay*DIV, delay in 2..5.
    task automatic wait_led(output int n);
        n = 0;
        while (!led && n < 64) begin
            step();
            n++;
        end
        check_range("led_delay", n, (MIN_DELAY) * DIV, (MIN_DELAY + 3) * DIV);
        check("led_delay_grid", n % DIV, 0);
    endtask

    // Waits for the LED, then presses stop between the k-th and (k+1)-th tick.
    task automatic play_round(int k, int rnd);
        int n;
        wait_led(n);
        push_exp($sformatf("round%0d", rnd), to_bcd(k), rnd, 0, 0, 0);
        scores.push_back(k);
        if (rnd == ROUNDS) begin
            push_exp("average", to_bcd(avg_of_scores()), rnd, 0, 1, 0);
        end
        repeat (DIV * k + $urandom_range(1, DIV - 1) - 1) step();
        pulse_stop();
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!session_done && n < 40) begin
            step();
            n++;
        end
        // One RESULT cycle, then at most 16 cycles of conversion.
        check_range("avg_latency", n, 2, 17);
    endtask

    task automatic monitor();
        logic [3:0] pr;
        logic       pf;
        logic       ps;
        exp_t       e;
        pr = 4'd0;
        pf = 1'b0;
        ps = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset && ((round_idx != pr && round_idx != 4'd0) || (foul && !pf) ||
                           (session_done && !ps))) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_event: digits=%0h round=%0d foul=%0b done=%0b",
                             digits, round_idx, foul, session_done);
                end else begin
                    e = sbq.pop_front();
                    check({e.name, ".digits"}, {16'd0, digits}, e.dig);
                    check({e.name, ".round"}, {28'd0, round_idx}, e.rnd);
                    check({e.name, ".foul"}, {31'd0, foul}, e.fl);
                    check({e.name, ".done"}, {31'd0, session_done}, e.sd);
                    check({e.name, ".led"}, {31'd0, led}, e.ld);
                end
            end
            pr = round_idx;
            pf = foul;
            ps = session_done;
        end
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int k;
        reset    = 1'b1;
        start    = 1'b0;
        stop     = 1'b0;
        show_avg = 1'b1;
        fork
            monitor();
        join_none

        // Reset values.
        repeat (3) step();
        check("reset.digits", {16'd0, digits}, 32'hCABC);
        check("reset.led", {31'd0, led}, 0);
        check("reset.round", {28'd0, round_idx}, 0);
        check("reset.foul", {31'd0, foul}, 0);
        check("reset.done", {31'd0, session_done}, 0);
        reset = 1'b0;
        step();
        check("idle.digits", {16'd0, digits}, 32'hCABC);

        // Reset in the middle of TIMING aborts to IDLE.
        pulse_start();
        check("wait.digits", {16'd0, digits}, 32'hCCCC);
        wait_led(n);
        repeat ($urandom_range(1, 6)) step();
        reset = 1'b1;
        step();
        check("midreset.digits", {16'd0, digits}, 32'hCABC);
        check("midreset.led", {31'd0, led}, 0);
        check("midreset.round", {28'd0, round_idx}, 0);
        reset = 1'b0;
        repeat ($urandom_range(1, 4)) step();

        // Session 1: scores 5, 3, 7, 9 with two false starts.
        scores.delete();
        pulse_start();
        repeat ($urandom_range(0, 5)) step();
        push_exp("foul1", 32'hDCCC, 0, 1, 0, 0);
        pulse_stop();
        repeat ($urandom_range(0, 3)) step();
        pulse_start();
        check("refoul1.foul", {31'd0, foul}, 0);
        check("refoul1.digits", {16'd0, digits}, 32'hCCCC);
        play_round(5, 1);
        check("round1.led_drop", {31'd0, led}, 0);
        pulse_both();
        check("result_both.foul", {31'd0, foul}, 0);
        check("result_both.digits", {16'd0, digits}, 32'hCCCC);
        check("result_both.round", {28'd0, round_idx}, 1);
        play_round(3, 2);
        repeat ($urandom_range(0, 4)) step();
        pulse_start();
        repeat ($urandom_range(0, 4)) step();
        push_exp("foul2", 32'hDCCC, 2, 1, 0, 0);
        pulse_both();
        pulse_start();
        check("refoul2.foul", {31'd0, foul}, 0);
        check("refoul2.round", {28'd0, round_idx}, 2);
        play_round(7, 3);
        pulse_start();
        play_round(9, 4);
        wait_done();

        show_avg = 1'b0;
        step();
        check("show_last", {16'd0, digits}, to_bcd(9));
        show_avg = 1'b1;
        step();
        check("show_avg", {16'd0, digits}, to_bcd(avg_of_scores()));
        pulse_stop();
        check("result_stop.round", {28'd0, round_idx}, ROUNDS);
        check("result_stop.done", {31'd0, session_done}, 1);

        // Session 2: random scores.
        scores.delete();
        pulse_start();
        check("restart.round", {28'd0, round_idx}, 0);
        check("restart.done", {31'd0, session_done}, 0);
        for (int r = 1; r <= ROUNDS; r++) begin
            k = $urandom_range(1, 12);
            play_round(k, r);
            if (r < ROUNDS) begin
                repeat ($urandom_range(0, 3)) step();
                pulse_start();
            end
        end
        wait_done();
        show_avg = 1'b0;
        step();
        check("s2.show_last", {16'd0, digits}, to_bcd(scores[ROUNDS-1]));
        show_avg = 1'b1;

        // Timeout: no stop, round closes with 9999.
        scores.delete();
        pulse_start();
        wait_led(n);
        push_exp("timeout", to_bcd(9999), 1, 0, 0, 0);
        n = 0;
        while (round_idx != 4'd1 && n < 40100) begin
            step();
            n++;
        end
        check("timeout_cycles", n, 9999 * DIV);
        repeat (3) step();

        check("scoreboard_left", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
